// File: rtl/note_key_if.sv
// Display-side bundle carrying the accepted {TOM, nota} note code, its
// valid flag, the press/release strobes and the multi-key flag.
// The encoder drives it through the master modport; the seven-segment
// note display consumes it through the slave modport.
interface note_key_if;
    logic       TOM;
    logic [2:0] nota;
    logic       valid;
    logic       press;
    logic       release_strobe;
    logic       multi;

    modport master (
        output TOM,
        output nota,
        output valid,
        output press,
        output release_strobe,
        output multi
    );

    modport slave (
        input TOM,
        input nota,
        input valid,
        input press,
        input release_strobe,
        input multi
    );
endinterface

// File: rtl/note_key_encoder.sv
// Note keyboard front end: synchronises the 8 raw note keys and the tone
// switch, priority-encodes the lowest pressed key, debounces presses and
// releases over DEB_CYCLES stable cycles, and presents a registered
// {TOM, nota} code with valid, press/release strobes and a multi-key flag.
module note_key_encoder #(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   key,
    input  logic         tom_sw,
    note_key_if.master   disp
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [8:0]       sync1, sync2;
    logic [7:0]       key_s;
    logic             tom_s;

    logic             any;
    logic [2:0]       idx;
    logic [3:0]       cand;
    logic             multi_n;

    state_t           state, state_n;
    logic [3:0]       ref_code, ref_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       code_q, code_n;
    logic             valid_q, valid_n;
    logic             press_q, press_n;
    logic             rel_q, rel_n;
    logic             multi_q;

    // Two-flop synchroniser for the 9 asynchronous raw inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the
            // pre-edge values, giving a true two-stage pipeline.
            sync1 <= {tom_sw, key};
            sync2 <= sync1;
        end
    end

    assign key_s = sync2[7:0];
    assign tom_s = sync2[8];

    // Candidate code: lowest-numbered pressed key plus the tone bit.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any branch, so no path can leave it unassigned and infer a latch.
        any     = |key_s;
        idx     = '0;
        multi_n = ($countones(key_s) > 1);
        for (int i = 7; i >= 0; i--) begin
            if (key_s[i]) begin
                idx = 3'(i);
            end
        end
        cand = {tom_s, idx};
    end

    // Debounce FSM: next state, reference/counter updates and strobes.
    always_comb begin
        state_n = state;
        ref_n   = ref_code;
        cnt_n   = cnt;
        code_n  = code_q;
        valid_n = valid_q;
        press_n = 1'b0;
        rel_n   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (any) begin
                    ref_n   = cand;
                    cnt_n   = '0;
                    state_n = ST_DEBOUNCE;
                end
            end

            ST_DEBOUNCE: begin
                if (any) begin
                    if (cand == ref_code) begin
                        if (cnt == CNT_LAST) begin
                            code_n  = ref_code;
                            valid_n = 1'b1;
                            press_n = 1'b1;
                            state_n = ST_HELD;
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                    end else begin
                        ref_n = cand;
                        cnt_n = '0;
                    end
                end else begin
                    // A still-valid code has to debounce its release too.
                    cnt_n   = '0;
                    state_n = valid_q ? ST_RELEASE : ST_IDLE;
                end
            end

            ST_HELD: begin
                if (!any) begin
                    cnt_n   = '0;
                    state_n = ST_RELEASE;
                end else if (cand != ref_code) begin
                    // Old code stays on the display while the new one settles.
                    ref_n   = cand;
                    cnt_n   = '0;
                    state_n = ST_DEBOUNCE;
                end
            end

            ST_RELEASE: begin
                if (!any) begin
                    if (cnt == CNT_LAST) begin
                        valid_n = 1'b0;
                        rel_n   = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end else if (cand == code_q) begin
                    // Short dropout of the displayed key: resume silently and
                    // re-anchor the reference so HELD compares against it.
                    ref_n   = cand;
                    state_n = ST_HELD;
                end else begin
                    ref_n   = cand;
                    cnt_n   = '0;
                    state_n = ST_DEBOUNCE;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, reference, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ref_code <= '0;
            cnt      <= '0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
            multi_q  <= 1'b0;
        end else begin
            state    <= state_n;
            ref_code <= ref_n;
            cnt      <= cnt_n;
            code_q   <= code_n;
            valid_q  <= valid_n;
            press_q  <= press_n;
            rel_q    <= rel_n;
            multi_q  <= multi_n;
        end
    end

    assign disp.TOM            = code_q[3];
    assign disp.nota           = code_q[2:0];
    assign disp.valid          = valid_q;
    assign disp.press          = press_q;
    assign disp.release_strobe = rel_q;
    assign disp.multi          = multi_q;

endmodule

// File: tb/tb_note_key_encoder.sv
// Bench for note_key_encoder. Each driven input cycle is run through a
// run-length reference model that pushes the expected output beat two
// clocks later; a monitor pops one beat per clock and compares.
module tb_note_key_encoder;

    localparam int DEB = 4;

    typedef struct packed {
        logic       tom;
        logic [2:0] nota;
        logic       valid;
        logic       press;
        logic       rls;
        logic       multi;
    } beat_t;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [7:0] key    = '0;
    logic       tom_sw = 1'b0;

    note_key_if disp();

    note_key_encoder #(
        .DEB_CYCLES (DEB),
        .CNT_W      (5)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .key    (key),
        .tom_sw (tom_sw),
        .disp   (disp.master)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    beat_t exp_q[$];
    bit    mon_en = 1'b0;
    int    dut_press_cnt = 0;
    int    dut_rel_cnt   = 0;

    // Reference model state: value seen by the debouncer (-1 = no key),
    // length of the current run of that value, whether the run must be
    // debounced, and the accepted code/valid.
    int         m_prev;
    int         m_run;
    bit         m_armed;
    bit         m_valid;
    logic [3:0] m_code;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_prev  = -1;
        m_run   = 1000;
        m_armed = 1'b0;
        m_valid = 1'b0;
        m_code  = '0;
    endtask

    // Expected beat after the edge that first samples this input plus two.
    task automatic model_step(input logic [7:0] k, input logic t);
        beat_t b;
        int    v;
        b = '0;
        v = -1;
        for (int i = 7; i >= 0; i--) begin
            if (k[i]) v = (t ? 8 : 0) + i;
        end
        if (v != m_prev) begin
            m_run   = 1;
            // A key returning after a short gap to the still-valid code is
            // resumed without debouncing; any other key run is debounced.
            m_armed = (v >= 0) && !(m_prev < 0 && m_valid && v == int'(m_code));
        end else if (m_run < 1000) begin
            m_run++;
        end
        m_prev = v;
        if (v >= 0 && m_armed && m_run == DEB + 1) begin
            m_code  = 4'(v);
            m_valid = 1'b1;
            b.press = 1'b1;
        end
        if (v < 0 && m_valid && m_run == DEB + 1) begin
            m_valid = 1'b0;
            b.rls   = 1'b1;
        end
        b.tom   = m_code[3];
        b.nota  = m_code[2:0];
        b.valid = m_valid;
        b.multi = ($countones(k) > 1);
        exp_q.push_back(b);
    endtask

    // Called at a negedge; leaves the caller at a negedge.
    task automatic drive(input logic [7:0] k, input logic t, input int n);
        repeat (n) begin
            key    = k;
            tom_sw = t;
            model_step(k, t);
            @(negedge clk);
        end
    endtask

    task automatic prime();
        beat_t z;
        z = '0;
        exp_q.push_back(z);
        exp_q.push_back(z);
        mon_en = 1'b1;
    endtask

    task automatic drain();
        repeat (2) @(posedge clk);
        #2;
        mon_en = 1'b0;
        check("sb_left", exp_q.size(), 0);
        @(negedge clk);
    endtask

    // Monitor: one output beat per clock, sampled just after the edge.
    initial begin
        beat_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (disp.press)          dut_press_cnt++;
                if (disp.release_strobe) dut_rel_cnt++;
            end
            if (mon_en) begin
                a = {disp.TOM, disp.nota, disp.valid, disp.press,
                     disp.release_strobe, disp.multi};
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow at %0t: got beat %h expected none", $time, a);
                end else begin
                    e = exp_q.pop_front();
                    check("beat{tom,nota,valid,press,rel,multi}", a, e);
                end
            end
        end
    end

    initial begin
        int         p0, r0;
        logic [3:0] cc;
        logic [7:0] k;
        model_reset();

        // Reset state.
        #12;
        check("reset_outputs",
              {disp.TOM, disp.nota, disp.valid, disp.press, disp.release_strobe, disp.multi}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        prime();

        // Clean press then release.
        p0 = dut_press_cnt; r0 = dut_rel_cnt;
        drive(8'h08, 1'b1, 20);
        drive(8'h00, 1'b1, 20);
        check("clean_nota_kept", disp.nota, 3'b011);
        check("clean_tom_kept", disp.TOM, 1'b1);
        check("clean_valid_low", disp.valid, 1'b0);
        check("clean_press_cnt", dut_press_cnt - p0, 1);
        check("clean_rel_cnt", dut_rel_cnt - r0, 1);
        drive(8'h00, 1'b0, 4);

        // Bounce shorter than the debounce window.
        p0 = dut_press_cnt;
        drive(8'h20, 1'b0, 3);
        drive(8'h00, 1'b0, 12);
        check("bounce_press_cnt", dut_press_cnt - p0, 0);
        check("bounce_valid", disp.valid, 1'b0);

        // Multi-key, then one key lifted.
        p0 = dut_press_cnt;
        drive(8'h44, 1'b0, 12);
        drive(8'h40, 1'b0, 12);
        check("multi_nota_after", disp.nota, 3'b110);
        drive(8'h00, 1'b0, 12);
        check("multi_press_cnt", dut_press_cnt - p0, 2);

        // Key change with no gap.
        p0 = dut_press_cnt; r0 = dut_rel_cnt;
        drive(8'h02, 1'b0, 12);
        drive(8'h10, 1'b0, 12);
        check("change_nota", disp.nota, 3'b100);
        check("change_rel_while_held", dut_rel_cnt - r0, 0);
        drive(8'h00, 1'b0, 12);
        check("change_press_cnt", dut_press_cnt - p0, 2);

        // Short release glitch.
        p0 = dut_press_cnt; r0 = dut_rel_cnt;
        drive(8'h04, 1'b1, 12);
        drive(8'h00, 1'b1, 2);
        drive(8'h04, 1'b1, 12);
        check("glitch_valid", disp.valid, 1'b1);
        check("glitch_rel_cnt", dut_rel_cnt - r0, 0);
        drive(8'h00, 1'b0, 12);
        check("glitch_press_cnt", dut_press_cnt - p0, 1);

        // Sweep of all 16 {tom_sw, note} codes.
        p0 = dut_press_cnt; r0 = dut_rel_cnt;
        for (int c = 0; c < 16; c++) begin
            cc = c[3:0];
            k  = 8'h01 << cc[2:0];
            drive(k, cc[3], 12);
            check("sweep_code", {disp.TOM, disp.nota}, cc);
            drive(8'h00, 1'b0, 12);
        end
        check("sweep_press_cnt", dut_press_cnt - p0, 16);
        check("sweep_rel_cnt", dut_rel_cnt - r0, 16);

        // Randomised segments: no key, single key, or several keys.
        for (int s = 0; s < 60; s++) begin
            int sel;
            sel = int'($urandom_range(0, 3));
            if (sel == 0)      k = 8'h00;
            else if (sel == 3) k = 8'($urandom_range(1, 255));
            else               k = 8'h01 << $urandom_range(0, 7);
            drive(k, 1'($urandom_range(0, 1)), int'($urandom_range(1, 10)));
        end
        drive(8'h80, 1'b1, 12);
        drain();

        // Reset asserted while a new key is debouncing.
        key = 8'h02;
        tom_sw = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check("pre_reset_valid", disp.valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs",
              {disp.TOM, disp.nota, disp.valid, disp.press, disp.release_strobe, disp.multi}, 8'h00);
        key = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        prime();
        for (int s = 0; s < 20; s++) begin
            drive(8'h01 << $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                  int'($urandom_range(2, 9)));
        end
        drive(8'h00, 1'b0, 12);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
